freq_meter: RTL and testbench

- Measurement end of the generator datapath: samples an 8-bit offset-binary waveform, as driven to the DAC or read back from an ADC, on every clk.
- Counts rising zero crossings, with hysteresis, over a fixed gate window.
- At the end of each window reports the frequency and the peak-to-peak amplitude.
- With the default gate of fclk cycles the frequency reads directly in Hz, in the same units as the generator's freq word.

---
 rtl/freq_meter.sv | 146 ++++++++++++++
 tb/tb_freq_meter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Frequency / amplitude meter: counts hysteresis-qualified rising zero crossings
// of an offset-binary sample stream over a fixed gate window and reports peak-to-peak.
module freq_meter #(
    parameter int width       = 8,
    parameter int fclk        = 50_000_000,
    parameter int gate_cycles = fclk,
    parameter int hyst        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] in,
    output logic [31:0]      freq,
    output logic [width-1:0] amp,
    output logic             freq_valid
);

    localparam int                      gate_w    = (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    localparam logic [gate_w-1:0]       gate_last = gate_w'(gate_cycles - 1);
    localparam logic [width-1:0]        mid_scale = {1'b1, {(width-1){1'b0}}};
    localparam logic signed [width-1:0] s_most_pos = {1'b0, {(width-1){1'b1}}};
    localparam logic signed [width-1:0] s_most_neg = {1'b1, {(width-1){1'b0}}};
    localparam logic signed [width-1:0] hyst_pos   = width'(hyst);
    localparam logic signed [width-1:0] hyst_neg   = width'(-hyst);

    typedef enum logic [1:0] {
        ARM,
        LOW,
        HIGH
    } det_state_e;

    logic [width-1:0]        sample_q,   sample_d;
    logic                    run_q,      run_d;
    det_state_e              state_q,    state_d;
    logic [gate_w-1:0]       gate_q,     gate_d;
    logic [31:0]             edge_cnt_q, edge_cnt_d;
    logic signed [width-1:0] max_q,      max_d;
    logic signed [width-1:0] min_q,      min_d;
    logic [31:0]             freq_q,     freq_d;
    logic [width-1:0]        amp_q,      amp_d;
    logic                    valid_q,    valid_d;

    logic signed [width-1:0] s;
    logic signed [width-1:0] max_n;
    logic signed [width-1:0] min_n;
    logic                    edge_det;
    logic                    terminal;
    logic [31:0]             edge_sum;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sample_d = in;
        run_d    = 1'b1;

        s = {~sample_q[width-1], sample_q[width-2:0]};

        state_d  = state_q;
        edge_det = 1'b0;
        if (run_q) begin
            case (state_q)
                ARM: begin
                    if (s >= hyst_pos) begin
                        state_d = HIGH;
                    end else if (s <= hyst_neg) begin
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (s >= hyst_pos) begin
                        state_d  = HIGH;
                        edge_det = 1'b1;
                    end
                end
                HIGH: begin
                    if (s <= hyst_neg) begin
                        state_d = LOW;
                    end
                end
                default: state_d = ARM;
            endcase
        end

        // run_q holds the gate off for the first cycle so every window sees real samples.
        terminal = run_q && (gate_q == gate_last);
        gate_d   = gate_q;
        if (run_q) begin
            gate_d = terminal ? '0 : gate_q + 1'b1;
        end

        edge_sum = (edge_det && (edge_cnt_q != '1)) ? edge_cnt_q + 32'd1 : edge_cnt_q;

        max_n = (s > max_q) ? s : max_q;
        min_n = (s < min_q) ? s : min_q;

        edge_cnt_d = edge_cnt_q;
        max_d      = max_q;
        min_d      = min_q;
        freq_d     = freq_q;
        amp_d      = amp_q;
        valid_d    = 1'b0;
        if (terminal) begin
            freq_d     = edge_sum;
            // max_n >= min_n, so the difference is non-negative and fits in width bits.
            amp_d      = max_n - min_n;
            valid_d    = 1'b1;
            edge_cnt_d = '0;
            max_d      = s;
            min_d      = s;
        end else if (run_q) begin
            edge_cnt_d = edge_sum;
            max_d      = max_n;
            min_d      = min_n;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q   <= mid_scale;
            run_q      <= 1'b0;
            state_q    <= ARM;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            max_q      <= s_most_neg;
            min_q      <= s_most_pos;
            freq_q     <= '0;
            amp_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            run_q      <= run_d;
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
            freq_q     <= freq_d;
            amp_q      <= amp_d;
            valid_q    <= valid_d;
        end
    end

    assign freq       = freq_q;
    assign amp        = amp_q;
    assign freq_valid = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: gate of 1000 clks, hysteresis 8, 8-bit samples,
// one sample driven per clk, reports captured at the negedge after they appear.
module tb_freq_meter;

    localparam int W = 8;
    localparam int G = 1000;
    localparam int H = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic [31:0]   freq;
    logic [W-1:0]  amp;
    logic          freq_valid;

    int          checks = 0;
    int          errors = 0;
    int          nsamp  = 0;
    int          nrep   = 0;
    int          rep_at = 0;
    logic [31:0] rep_freq = '0;
    logic [31:0] rep_amp  = '0;

    freq_meter #(
        .width      (W),
        .fclk       (G),
        .gate_cycles(G),
        .hyst       (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .freq      (freq),
        .amp       (amp),
        .freq_valid(freq_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one sample across one rising edge; called and returning at a negedge.
    task automatic feed(input logic [7:0] v);
        din = v;
        @(negedge clk);
        nsamp++;
        if (freq_valid) begin
            nrep++;
            rep_at   = nsamp;
            rep_freq = freq;
            rep_amp  = {24'h0, amp};
        end
    endtask

    task automatic expect_report(input string tag, input int at, input logic [31:0] f,
                                 input logic [31:0] a, input int n);
        check({tag, "_count"}, nrep, n);
        check({tag, "_at"}, rep_at, at);
        check({tag, "_freq"}, rep_freq, f);
        check({tag, "_amp"}, rep_amp, a);
    endtask

    function automatic logic [7:0] square(input int off, input bit high_first);
        bit first_half;
        first_half = ((off - 1) % 100) < 50;
        return (first_half == high_first) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] tri_wave(input int i);
        int p;
        int t;
        p = i % 256;
        t = (p <= 128) ? p : 256 - p;
        return 8'(64 + t);
    endfunction

    initial begin
        rst = 1'b0;
        din = 8'h00;
        @(negedge clk);

        // Held in reset with a toggling input.
        for (int i = 0; i < 8; i++) feed((i % 2) ? 8'hFF : 8'h00);
        check("rst_freq", freq, 32'h0);
        check("rst_amp", 32'(amp), 32'h0);
        check("rst_valid", 32'(freq_valid), 32'h0);
        check("rst_nrep", nrep, 0);

        rst   = 1'b1;
        nsamp = 0;

        // Square wave 0x00/0xFF, period 100, starting low: 10 rises per window.
        for (int off = 1; off <= G; off++) feed(square(off, 1'b0));
        check("no_early_valid", nrep, 0);
        feed(square(1, 1'b0));
        check("first_valid_at", rep_at, G + 1);
        check("first_valid_hi", 32'(freq_valid), 32'h1);
        feed(square(2, 1'b0));
        check("valid_one_cycle", 32'(freq_valid), 32'h0);
        // Terminal sample 0x85 sits inside the hysteresis band and seeds the next window.
        for (int off = 3; off < G; off++) feed(square(off, 1'b0));
        feed(8'h85);
        expect_report("sq0", 1001, 32'd10, 32'hFF, 1);

        // Chatter +-5 around mid-scale.
        for (int off = 1; off <= G; off++) feed((off % 2) ? 8'h7B : 8'h85);
        expect_report("sq1", 2001, 32'd10, 32'hFF, 2);

        // Exact thresholds, spikes without a re-arming dip, then +-7 chatter: 2 rises.
        for (int off = 1;   off <= 10;  off++) feed(8'h78);
        for (int off = 11;  off <= 20;  off++) feed(8'h88);
        for (int off = 21;  off <= 30;  off++) feed(8'h78);
        for (int off = 31;  off <= 40;  off++) feed(8'h88);
        for (int off = 41;  off <= 500; off++) feed((off % 2) ? 8'h7B : 8'h89);
        for (int off = 501; off <= G;   off++) feed((off % 2) ? 8'h87 : 8'h79);
        expect_report("chat", 3001, 32'd0, 32'h0A, 3);

        // One rise mid-window and one in the terminal cycle.
        for (int off = 1;   off <= 100; off++) feed(8'h00);
        for (int off = 101; off <= 200; off++) feed(8'hFF);
        for (int off = 201; off <  G;   off++) feed(8'h00);
        feed(8'hFF);
        expect_report("hyst", 4001, 32'd2, 32'h11, 4);

        // Constant input: the terminal rise must not leak into this window.
        for (int off = 1; off <= G; off++) feed(8'hFF);
        expect_report("term", 5001, 32'd2, 32'hFF, 5);

        // Half a window of square wave (several rises), then a 3-clk reset pulse.
        for (int off = 1; off <= 500; off++) feed(square(off, 1'b0));
        expect_report("const", 6001, 32'd0, 32'h0, 6);
        rst = 1'b0;
        feed(8'h00);
        check("mid_rst_freq", freq, 32'h0);
        check("mid_rst_amp", 32'(amp), 32'h0);
        feed(8'hFF);
        feed(8'h00);
        check("mid_rst_nrep", nrep, 6);
        rst   = 1'b1;
        nsamp = 0;

        // Starts high: the ARM->HIGH rise is not counted, so 9 rises.
        for (int off = 1; off < G; off++) feed(square(off, 1'b1));
        feed(8'h60);
        check("no_partial", nrep, 6);

        // Triangle 0x40..0xC0, period 256: 4 rises.
        for (int i = 0; i < G; i++) feed(tri_wave(i));
        expect_report("post_rst", 1001, 32'd9, 32'hFF, 7);

        // Edge counter preloaded near full scale, then 11 rises: saturates.
        for (int off = 1; off <= 10; off++) feed(8'h00);
        force dut.edge_cnt_q = 32'hFFFF_FFFD;
        feed(8'h00);
        release dut.edge_cnt_q;
        for (int off = 12; off < G; off++) feed(square(off - 11, 1'b1));
        feed(8'hFF);
        expect_report("tri", 2001, 32'd4, 32'h80, 8);

        // All-zero window seeded by the previous 0xFF terminal sample.
        for (int off = 1; off <= G; off++) feed(8'h00);
        expect_report("sat", 3001, 32'hFFFF_FFFF, 32'hFF, 9);
        feed(8'h00);
        expect_report("seed", 4001, 32'd0, 32'hFF, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
